instr_fetch_controller: RTL

Sequencing front end for the single-cycle ARM core's instruction memory. Owns the program counter and drives the memory's word-indexed read port, which is combinational, 32-bit data, word index in `addr[9:0]`. Buffers fetched words in a 2-entry prefetch FIFO and hands them to decode over a valid/ready handshake. Handles branch redirects (flush) and halt/resume of fetch.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    // Fetch sequencing state: RUN issues fetches, HALT does not.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // One prefetch FIFO entry: byte address plus fetched instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Byte increment between consecutive instruction words.
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch FIFO with flush. The head is read straight from a
// storage register, so nothing combinational reaches o_head from i_push_data.
//
// Handshake: an entry is written when i_push is high and there is room
// (not full, or a pop in the same cycle frees a slot). An entry is removed
// when i_pop is high and the FIFO is not empty. i_flush empties the FIFO
// and overrides both push and pop in that cycle.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; a flush resets pointers and count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, the RUN/HALT state and the
// fetch counter, and feeds fetched words to decode through a 2-entry FIFO.
//
// Decode handshake: the head is transferred on a cycle where instr_valid
// and instr_ready are both high. instr/instr_pc stay stable while
// instr_valid is high and instr_ready is low. A branch flushes the FIFO,
// dropping any transfer that coincides with it.
module instr_fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted,
    output logic [31:0] fetch_count
);

    // The FIFO is hard-wired to two entries in this revision.
    if (FIFO_DEPTH != 2) begin : g_bad_depth
        $error("instr_fetch_controller: FIFO_DEPTH must be 2");
    end

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;

    logic         w_pop;
    logic         w_issue;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;

    assign w_pop       = !w_empty && instr_ready;
    // A halt request blocks the issue in the very cycle it arrives.
    assign w_issue     = (r_state == RUN) && !halt_req && !branch_valid
                         && (!w_full || w_pop);
    assign w_push_data = '{pc: r_pc, instr: imem_data};

    assign imem_addr   = {2'b00, r_pc[31:2]};
    assign instr_valid = !w_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign halted      = (r_state == HALT);
    assign fetch_count = r_fetch_count;

    fetch_fifo u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (branch_valid),
        .i_push      (w_issue),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // FSM next state; halt_req wins over a simultaneous resume.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (halt_req) w_next_state = HALT;
            HALT:    if (resume && !halt_req) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC and fetch counter; a branch redirects the PC in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            if (branch_valid) begin
                r_pc <= {branch_target[31:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (w_issue) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

endmodule
